// File: rtl/vdp_blend_output.sv
// Final colour stage: palette lookup of primary and masked indices, alpha-over
// blend of the masked colour onto the primary, and sync alignment to the RGB output.
module vdp_blend_output #(
    parameter int SYNC_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pixel_valid,
    input  logic [7:0]            prioritized_pixel,
    input  logic [4:0]            prioritized_layer,
    input  logic [7:0]            prioritized_masked_pixel,
    input  logic [4:0]            prioritized_masked_layer,
    input  logic [SYNC_WIDTH-1:0] sync_in,
    input  logic                  frame_start,
    input  logic [11:0]           background_color,
    input  logic                  blend_enable,
    output logic [7:0]            palette_addr_a,
    output logic [7:0]            palette_addr_b,
    input  logic [15:0]           palette_data_a,
    input  logic [15:0]           palette_data_b,
    output logic                  out_valid,
    output logic [3:0]            out_r,
    output logic [3:0]            out_g,
    output logic [3:0]            out_b,
    output logic [SYNC_WIDTH-1:0] sync_out
);

    function automatic logic [4:0] alpha_weight(input logic [3:0] a);
        return (a == 4'hF) ? 5'd16 : {1'b0, a};
    endfunction

    function automatic logic [3:0] blend_ch(input logic [3:0] f, input logic [3:0] p,
                                            input logic [4:0] w);
        logic [8:0] acc;
        acc = 9'(f) * 9'(w) + 9'(p) * 9'(5'd16 - w);
        return acc[7:4];
    endfunction

    function automatic logic [11:0] blend_px(input logic [11:0] p, input logic [15:0] fb);
        logic [4:0] w;
        w = alpha_weight(fb[15:12]);
        return {blend_ch(fb[11:8], p[11:8], w), blend_ch(fb[7:4], p[7:4], w),
                blend_ch(fb[3:0], p[3:0], w)};
    endfunction

    logic                  unused_alpha_a;
    assign unused_alpha_a = ^palette_data_a[15:12];

    logic [11:0]           shadow_bg_q;
    logic                  shadow_blend_q;
    logic                  vld_p1_q, vld_p2_q, vld_p3_q;
    logic [SYNC_WIDTH-1:0] sync_p1_q, sync_p2_q, sync_p3_q;
    logic [7:0]            idx_a_p1_q, idx_b_p1_q;
    logic                  prim_p1_q, prim_p2_q, prim_p3_q;
    logic                  mask_p1_q, blend_p1_q, mix_p2_q, mix_p3_q;
    logic [11:0]           bg_p1_q, bg_p2_q, bg_p3_q;
    logic [11:0]           data_a_p3_q;
    logic [15:0]           data_b_p3_q;
    logic                  out_valid_q;
    logic [11:0]           rgb_q, rgb_d;
    logic [SYNC_WIDTH-1:0] sync_out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bg_q    <= '0;
            shadow_blend_q <= 1'b0;
            vld_p1_q       <= 1'b0;
            vld_p2_q       <= 1'b0;
            vld_p3_q       <= 1'b0;
            sync_p1_q      <= '0;
            sync_p2_q      <= '0;
            sync_p3_q      <= '0;
            idx_a_p1_q     <= '0;
            idx_b_p1_q     <= '0;
            out_valid_q    <= 1'b0;
            rgb_q          <= '0;
            sync_out_q     <= '0;
        end else begin
            if (frame_start) begin
                shadow_bg_q    <= background_color;
                shadow_blend_q <= blend_enable;
            end
            // S1: sample inputs; indices drive the palette read ports
            vld_p1_q   <= pixel_valid;
            sync_p1_q  <= sync_in;
            idx_a_p1_q <= prioritized_pixel;
            idx_b_p1_q <= prioritized_masked_pixel;
            // S1b/S2: controls wait for the palette read latency
            vld_p2_q   <= vld_p1_q;
            sync_p2_q  <= sync_p1_q;
            vld_p3_q   <= vld_p2_q;
            sync_p3_q  <= sync_p2_q;
            // S3: registered result
            out_valid_q <= vld_p3_q;
            rgb_q       <= rgb_d;
            sync_out_q  <= sync_p3_q;
        end
    end

    // Datapath side registers; their content is only observed under a valid flag.
    always_ff @(posedge clk) begin
        prim_p1_q   <= |prioritized_layer;
        mask_p1_q   <= |prioritized_masked_layer;
        bg_p1_q     <= shadow_bg_q;
        blend_p1_q  <= shadow_blend_q;
        prim_p2_q   <= prim_p1_q;
        mix_p2_q    <= blend_p1_q & mask_p1_q;
        bg_p2_q     <= bg_p1_q;
        prim_p3_q   <= prim_p2_q;
        mix_p3_q    <= mix_p2_q;
        bg_p3_q     <= bg_p2_q;
        data_a_p3_q <= palette_data_a[11:0];
        data_b_p3_q <= palette_data_b;
    end

    always_comb begin
        logic [11:0] prim_col;
        rgb_d    = '0;
        prim_col = prim_p3_q ? data_a_p3_q : bg_p3_q;
        if (vld_p3_q) begin
            rgb_d = mix_p3_q ? blend_px(prim_col, data_b_p3_q) : prim_col;
        end
    end

    assign palette_addr_a = idx_a_p1_q;
    assign palette_addr_b = idx_b_p1_q;
    assign out_valid      = out_valid_q;
    assign out_r          = rgb_q[11:8];
    assign out_g          = rgb_q[7:4];
    assign out_b          = rgb_q[3:0];
    assign sync_out       = sync_out_q;

endmodule

// File: tb/tb_vdp_blend_output.sv
// Bench for vdp_blend_output: directed scenarios then random traffic, compared
// against a cycle-slot queue of colours computed from the palette contents.
module tb_vdp_blend_output;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_valid = 1'b0;
    logic [7:0]  prioritized_pixel = '0;
    logic [4:0]  prioritized_layer = '0;
    logic [7:0]  prioritized_masked_pixel = '0;
    logic [4:0]  prioritized_masked_layer = '0;
    logic [1:0]  sync_in = '0;
    logic        frame_start = 1'b0;
    logic [11:0] background_color = '0;
    logic        blend_enable = 1'b0;
    logic [7:0]  palette_addr_a, palette_addr_b;
    logic [15:0] palette_data_a = '0, palette_data_b = '0;
    logic        out_valid;
    logic [3:0]  out_r, out_g, out_b;
    logic [1:0]  sync_out;

    vdp_blend_output #(.SYNC_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid),
        .prioritized_pixel(prioritized_pixel), .prioritized_layer(prioritized_layer),
        .prioritized_masked_pixel(prioritized_masked_pixel),
        .prioritized_masked_layer(prioritized_masked_layer),
        .sync_in(sync_in), .frame_start(frame_start), .background_color(background_color),
        .blend_enable(blend_enable), .palette_addr_a(palette_addr_a),
        .palette_addr_b(palette_addr_b), .palette_data_a(palette_data_a),
        .palette_data_b(palette_data_b), .out_valid(out_valid), .out_r(out_r),
        .out_g(out_g), .out_b(out_b), .sync_out(sync_out)
    );

    always #5 clk = ~clk;

    // Palette RAM: one cycle read latency on both ports.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    always @(posedge clk) begin
        palette_data_a <= mem_a[palette_addr_a];
        palette_data_b <= mem_b[palette_addr_b];
    end

    typedef struct {
        bit          vld;
        logic [11:0] rgb;
        logic [1:0]  sync;
        int          expl;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [11:0] m_bg;
    bit          m_be;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mix(input int f, input int p, input int a);
        int w;
        w = (a == 15) ? 16 : a;
        return (f * w + p * (16 - w)) / 16;
    endfunction

    function automatic logic [11:0] ref_color(input logic [4:0] l, input logic [7:0] i,
                                              input logic [4:0] ml, input logic [7:0] mi);
        int p[3], f[3], a, o[3];
        logic [11:0] pc;
        pc = (l == 0) ? m_bg : mem_a[i][11:0];
        for (int c = 0; c < 3; c++) begin
            p[c] = int'(pc[11-4*c -: 4]);
            f[c] = int'(mem_b[mi][11-4*c -: 4]);
        end
        a = int'(mem_b[mi][15:12]);
        if (!(m_be && ml != 0)) return pc;
        for (int c = 0; c < 3; c++) o[c] = mix(f[c], p[c], a);
        return {o[0][3:0], o[1][3:0], o[2][3:0]};
    endfunction

    task automatic prefill();
        exp_t z;
        z.vld = 0; z.rgb = '0; z.sync = '0; z.expl = -1;
        q = {};
        repeat (3) q.push_back(z);
    endtask

    task automatic step(input bit v, input logic [4:0] l, input logic [7:0] i,
                        input logic [4:0] ml, input logic [7:0] mi, input logic [1:0] s,
                        input bit fs, input logic [11:0] bg, input bit be, input int expl);
        exp_t e, h;
        pixel_valid = v; prioritized_layer = l; prioritized_pixel = i;
        prioritized_masked_layer = ml; prioritized_masked_pixel = mi; sync_in = s;
        frame_start = fs; background_color = bg; blend_enable = be;
        e.vld = v;
        e.rgb = v ? ref_color(l, i, ml, mi) : 12'h000;
        e.sync = s;
        e.expl = expl;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (fs) begin
            m_bg = bg;
            m_be = be;
        end
        h = q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(h.vld));
        chk("rgb", 32'({out_r, out_g, out_b}), 32'(h.rgb));
        chk("sync_out", 32'(sync_out), 32'(h.sync));
        if (h.expl >= 0) chk("rgb_directed", 32'({out_r, out_g, out_b}), 32'(h.expl));
        chk("palette_addr_a", 32'(palette_addr_a), 32'(i));
        chk("palette_addr_b", 32'(palette_addr_b), 32'(mi));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_rgb", 32'({out_r, out_g, out_b}), 0);
        chk("rst_sync_out", 32'(sync_out), 0);
        chk("rst_addr_a", 32'(palette_addr_a), 0);
        chk("rst_addr_b", 32'(palette_addr_b), 0);
        m_bg = '0;
        m_be = 0;
        prefill();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0] l, ml;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 16'($urandom);
            mem_b[k] = 16'($urandom);
        end
        mem_a[8'h12] = 16'hF123;
        mem_a[8'h20] = 16'h0000;
        mem_a[8'h21] = 16'h0468;
        mem_b[8'h30] = 16'h8F0F;
        mem_b[8'h31] = 16'h0F0F;
        mem_b[8'h32] = 16'hFF0F;
        do_reset();

        // Primary palette colour passes straight through
        step(1, 5'b00001, 8'h12, 0, 8'h00, 2'b00, 0, 12'h000, 0, 12'h123);
        idle(3);

        // Background: unlatched gives black, then latched value after frame_start
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, 12'hABC, 0, 12'h000);
        step(1, 0, 8'h00, 0, 8'h00, 0, 1, 12'hABC, 0, 12'h000);
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, 12'h000, 0, 12'hABC);
        idle(3);

        // Blend enabled through the shadow; alpha midpoint, zero and full
        step(0, 0, 0, 0, 0, 0, 1, 12'h000, 1, -1);
        step(1, 5'b00001, 8'h20, 5'b00010, 8'h30, 0, 0, 0, 0, 12'h707);
        step(1, 5'b00001, 8'h20, 5'b00010, 8'h31, 0, 0, 0, 0, 12'h000);
        step(1, 5'b00001, 8'h20, 5'b00010, 8'h32, 0, 0, 0, 0, 12'hF0F);
        step(1, 5'b00001, 8'h21, 5'b00010, 8'h30, 0, 0, 0, 0, 12'h93B);
        step(1, 5'b00001, 8'h21, 5'b00000, 8'h30, 0, 0, 0, 0, 12'h468);
        step(1, 5'b00000, 8'h21, 5'b00100, 8'h32, 0, 0, 0, 0, 12'hF0F);
        idle(3);

        // Shadow timing: same-edge frame_start uses old setting; raw toggles ignored
        step(0, 0, 0, 0, 0, 0, 1, 12'h000, 0, -1);
        step(1, 5'b00001, 8'h20, 5'b00010, 8'h30, 0, 1, 12'h000, 1, 12'h000);
        step(1, 5'b00001, 8'h20, 5'b00010, 8'h30, 0, 0, 12'h000, 1, 12'h707);
        step(1, 5'b00001, 8'h20, 5'b00010, 8'h30, 0, 0, 12'h000, 0, 12'h707);
        step(1, 5'b00001, 8'h20, 5'b00010, 8'h30, 0, 1, 12'h000, 0, 12'h707);
        step(1, 5'b00001, 8'h20, 5'b00010, 8'h30, 0, 0, 12'h000, 1, 12'h000);
        idle(3);

        // Alternating valid with sync pattern
        for (int k = 0; k < 6; k++)
            step(k[0] == 0, 5'b00001, 8'h12, 0, 0, (k[0] == 0) ? 2'b01 : 2'b10, 0, 0, 0,
                 (k[0] == 0) ? 12'h123 : 12'h000);
        idle(3);

        // Reset with three pixels in flight: none may emerge afterwards
        step(1, 5'b00001, 8'h12, 0, 0, 2'b11, 0, 0, 0, -1);
        step(1, 5'b00001, 8'h12, 0, 0, 2'b11, 0, 0, 0, -1);
        step(1, 5'b00001, 8'h12, 0, 0, 2'b11, 0, 0, 0, -1);
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            l  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'(1 << $urandom_range(0, 4));
            ml = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'(1 << $urandom_range(0, 4));
            step($urandom_range(0, 4) != 0, l, 8'($urandom), ml, 8'($urandom),
                 2'($urandom), $urandom_range(0, 15) == 0, 12'($urandom),
                 1'($urandom), -1);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
